// File: rtl/ram_refill_ctrl.sv
// Main-memory side of the L1: optional victim writeback then line fill.
// Parameters: ADDR_W, DATA_W, RAM_LATENCY (1..15).
// Ports: clock, reset_n (async, active-low);
//   request: req_valid/req_ready, req_rd, req_wb, rd_addr, wb_addr, wb_data;
//   response: resp_valid/resp_ready, resp_data;
//   status: busy.
// Optional macro RAM_REFILL_STATS_EN adds the outputs stat_fills and stat_wbs.
module ram_refill_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int RAM_LATENCY = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rd,
  input  logic              req_wb,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
`ifdef RAM_REFILL_STATS_EN
  output logic [7:0]        stat_fills,
  output logic [7:0]        stat_wbs,
`endif
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] LAT_M1 = 4'(RAM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_RD,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

  // Words are stored XOR their own address, so the all-zero
  // power-up image of the array reads back as mem[i] = i.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [DATA_W-1:0] rd_word;

  assign rd_word = mem_q[rd_addr_q] ^ DATA_W'(rd_addr_q);

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[wb_addr_q] <= wb_data_q ^ DATA_W'(wb_addr_q);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      rd_addr_q   <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      rd_addr_q   <= rd_addr_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      resp_data_q <= resp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    rd_addr_d   = rd_addr_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    resp_data_d = resp_data_q;
    mem_we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rd_d      = req_rd;
          rd_addr_d = rd_addr;
          wb_addr_d = wb_addr;
          wb_data_d = wb_data;
          cnt_d     = LAT_M1;
          if (req_wb) begin
            state_d = S_WB;
          end else if (req_rd) begin
            state_d = S_RD;
          end
        end
      end
      S_WB: begin
        if (cnt_q == 4'd0) begin
          mem_we = 1'b1;
          if (rd_q) begin
            state_d = S_RD;
            cnt_d   = LAT_M1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RD: begin
        if (cnt_q == 4'd0) begin
          // The write of a same-address victim lands on an
          // earlier edge, so the fill sees the new data.
          resp_data_d = rd_word;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = resp_data_q;

`ifdef RAM_REFILL_STATS_EN
  logic [7:0] fills_q;
  logic [7:0] wbs_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fills_q <= '0;
      wbs_q   <= '0;
    end else begin
      if (resp_valid && resp_ready && fills_q != 8'hFF) begin
        fills_q <= fills_q + 8'd1;
      end
      if (mem_we && wbs_q != 8'hFF) begin
        wbs_q <= wbs_q + 8'd1;
      end
    end
  end

  assign stat_fills = fills_q;
  assign stat_wbs   = wbs_q;
`endif

endmodule
